cla_mp_add_seq: RTL and testbench
=================================

// Module: cla_mp_add_seq
// PURPOSE
// - Multi-precision add/subtract sequencer around one cla_64bit instance.
// - Streams N pairs of 64-bit operand limbs, least-significant limb first, through the adder.
// - Chains the carry between limbs in a register, so wide operands cost 1 cycle/limb.
// - Emits sum limbs over a valid/ready stream and the final carry/borrow.
// - Sits between the operand buffer (upstream) and the result writer (downstream).
// PARAMETERS
// - LIMB_W  64  limb width; fixed by cla_64bit, must stay 64
// - CNT_W   8   width of the limb counter (max 2^CNT_W-1 limbs per operation)
// PORTS
// - clk        in   1       clock; single clock domain
// - rst_n      in   1       asynchronous, active-low reset
// - start      in   1       start an operation; sampled only in IDLE
// - num_limbs  in   CNT_W   limb count for this operation; latched on start
// - sub        in   1       0 = a+b, 1 = a-b; latched on start
// - busy       out  1       high from accepted start until the done pulse (inclusive)
// - in_valid   in   1       a_limb/b_limb valid
// - in_ready   out  1       sequencer accepts a limb pair
// - a_limb     in   LIMB_W  operand A limb
// - b_limb     in   LIMB_W  operand B limb
// - out_valid  out  1       sum_limb valid
// - out_ready  in   1       downstream accepts sum_limb
// - sum_limb   out  LIMB_W  result limb (registered)
// - out_last   out  1       qualifies the final limb; valid only while out_valid=1
// - done       out  1       1-cycle pulse after the last limb is accepted downstream
// - carry_out  out  1       final raw adder carry; held until the next start
//                           sub=1: carry_out=1 means no borrow (A>=B)
// BEHAVIOUR
// - Reset: all outputs 0, state IDLE, carry register 0, counter 0.
// - States and transitions:
//   - IDLE -> RUN on start && num_limbs!=0.
//     - Latch count and sub; carry register <= sub.
//     - start with num_limbs==0, or start outside IDLE: ignored, no done pulse.
//   - RUN -> DRAIN when the last limb pair is accepted.
//   - DRAIN -> IDLE when the last output is accepted.
//   - done=1 and carry_out <= carry register in the cycle after the final output handshake.
// - Signal rules:
//   - in_ready = (state==RUN) && (!out_valid || out_ready); single-entry output register, no bubble.
//   - Adder inputs: a = a_limb, b = sub ? ~b_limb : b_limb, cin = carry register.
//   - On an input accept (in_valid && in_ready), in one cycle:
//     - sum_limb <= adder sum; out_valid <= 1;
//     - carry register <= adder cout; remaining <= remaining-1;
//     - out_last <= (remaining==1).
//   - out_valid clears on out_ready unless a new limb is accepted in the same cycle (simultaneous accept+drain keeps out_valid=1).
//   - sum_limb/out_last stay stable while out_valid && !out_ready.
// - Timing: latency 1 cycle from input accept to out_valid; throughput 1 limb/cycle with out_ready=1.
// - Counter range: num_limbs up to 2^CNT_W-1; no wrap inside an operation.
// - Reset asserted mid-operation: immediate return to IDLE; partial results discarded; carry_out=0.
// STRUCTURE
// - Shared package: state encoding (IDLE, RUN, DRAIN) and LIMB_W=64 constant.
// - One sub-module: existing cla_64bit (a, b, cin, sum, cout), instantiated once and purely combinational.
// - Kept in this block: FSM, counter, carry register, output register.
// TESTING
// - Add, 2 limbs, A=0x0000..0001_FFFF..FFFF, B=0x0000..0000_0000..0001
//   -> sums 0x0, 0x2 (carry chained); out_last on limb 2; carry_out=0.
// - Sub, 1 limb, A=5, B=7 -> sum 0xFFFF_FFFF_FFFF_FFFE; carry_out=0 (borrow).
//   Sub, 1 limb, A=7, B=5 -> sum 2; carry_out=1.
// - Add, 3 limbs all 0xFFFF..FFFF + 0xFFFF..FFFF
//   -> sums 0xFF..FE, 0xFF..FF, 0xFF..FF; carry_out=1.
//   out_ready held 1 -> in_ready never drops; done 1 cycle after the 3rd output.
// - Backpressure: out_ready=0 for 5 cycles after limb 1
//   -> in_ready=0, sum_limb stable, no limb lost or duplicated.
// - Ignored starts: start with num_limbs=0 -> busy stays 0, no done;
//   start while busy -> ignored, operation completes unchanged.
// - Reset mid-RUN: assert rst_n=0 after limb 1 of 4
//   -> out_valid=0, busy=0, carry_out=0 immediately; next operation correct.

Source files
------------

// File: rtl/cla_mp_add_seq_pkg.sv
// Shared constants and types for the multi-precision add/subtract sequencer.
// Holds the limb width, the FSM state encoding and the output-register layout.
package cla_mp_add_seq_pkg;

  localparam int LIMB_W = 64;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

  typedef struct packed {
    logic [LIMB_W-1:0] sum;
    logic              last;
  } out_t;

endpackage

// File: rtl/cla_mp_add_seq_if.sv
// Control, operand-stream and result-stream bundle of the sequencer.
// master = operand buffer / result writer side, slave = sequencer side.
interface cla_mp_add_seq_if #(
  parameter int CNT_W = 8
);
  import cla_mp_add_seq_pkg::*;

  logic              start;
  logic [CNT_W-1:0]  num_limbs;
  logic              sub;
  logic              busy;
  logic              in_valid;
  logic              in_ready;
  logic [LIMB_W-1:0] a_limb;
  logic [LIMB_W-1:0] b_limb;
  logic              out_valid;
  logic              out_ready;
  logic [LIMB_W-1:0] sum_limb;
  logic              out_last;
  logic              done;
  logic              carry_out;

  modport master (
    output start, num_limbs, sub, in_valid, a_limb, b_limb, out_ready,
    input  busy, in_ready, out_valid, sum_limb, out_last, done, carry_out
  );

  modport slave (
    input  start, num_limbs, sub, in_valid, a_limb, b_limb, out_ready,
    output busy, in_ready, out_valid, sum_limb, out_last, done, carry_out
  );

endinterface

// File: rtl/cla_64bit.sv
// 64-bit carry-lookahead adder: 4-bit groups, lookahead carry between groups.
// Purely combinational, no flow control.
module cla_64bit
  import cla_mp_add_seq_pkg::*;
(
  input  logic [LIMB_W-1:0] a,
  input  logic [LIMB_W-1:0] b,
  input  logic              cin,
  output logic [LIMB_W-1:0] sum,
  output logic              cout
);

  localparam int NGRP = LIMB_W / 4;

  logic [LIMB_W-1:0] g;
  logic [LIMB_W-1:0] p;
  logic [LIMB_W-1:0] c;
  logic [NGRP-1:0]   grp_g;
  logic [NGRP-1:0]   grp_p;
  logic [NGRP:0]     grp_c;

  assign g = a & b;
  assign p = a ^ b;

  always_comb begin
    grp_g = '0;
    grp_p = '0;
    for (int k = 0; k < NGRP; k++) begin
      grp_g[k] = g[4*k+3]
               | (p[4*k+3] & g[4*k+2])
               | (p[4*k+3] & p[4*k+2] & g[4*k+1])
               | (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k]);
      grp_p[k] = &p[4*k +: 4];
    end
  end

  always_comb begin
    grp_c    = '0;
    grp_c[0] = cin;
    for (int k = 0; k < NGRP; k++) begin
      grp_c[k+1] = grp_g[k] | (grp_p[k] & grp_c[k]);
    end
  end

  // Inside a group the carry ripples from the group's lookahead carry-in.
  always_comb begin
    c = '0;
    for (int k = 0; k < NGRP; k++) begin
      c[4*k] = grp_c[k];
      for (int j = 0; j < 3; j++) begin
        c[4*k+j+1] = g[4*k+j] | (p[4*k+j] & c[4*k+j]);
      end
    end
  end

  assign sum  = p ^ c;
  assign cout = grp_c[NGRP];

endmodule

// File: rtl/cla_mp_add_seq.sv
// Streams limb pairs LS-first through one CLA, chaining carry; 1 cycle accept->out_valid.
// Single-entry output register: in_ready drops only while a held result is not taken.
module cla_mp_add_seq
  import cla_mp_add_seq_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input logic             clk,
  input logic             rst_n,
  cla_mp_add_seq_if.slave bus
);

  logic [1:0]        state_q, state_d;
  logic [CNT_W-1:0]  rem_q, rem_d;
  logic              sub_q, sub_d;
  logic              carry_q, carry_d;
  logic              out_vld_q, out_vld_d;
  logic              done_q, done_d;
  logic              cout_q, cout_d;
  out_t              out_q, out_d;

  logic [LIMB_W-1:0] add_b;
  logic [LIMB_W-1:0] add_sum;
  logic              add_cout;
  logic              in_rdy;
  logic              in_acc;
  logic              out_acc;
  logic              last_limb;

  assign in_rdy    = (state_q == ST_RUN) && (!out_vld_q || bus.out_ready);
  assign in_acc    = bus.in_valid && in_rdy;
  assign out_acc   = out_vld_q && bus.out_ready;
  assign last_limb = (rem_q == CNT_W'(1));

  // Subtraction is a + ~b + 1; the +1 comes from the carry register seeded with sub.
  assign add_b = sub_q ? ~bus.b_limb : bus.b_limb;

  cla_64bit u_cla (
    .a    (bus.a_limb),
    .b    (add_b),
    .cin  (carry_q),
    .sum  (add_sum),
    .cout (add_cout)
  );

  always_comb begin
    state_d   = state_q;
    rem_d     = rem_q;
    sub_d     = sub_q;
    carry_d   = carry_q;
    out_d     = out_q;
    out_vld_d = out_vld_q;
    done_d    = 1'b0;
    cout_d    = cout_q;

    case (state_q)
      ST_IDLE: begin
        if (bus.start && (bus.num_limbs != '0)) begin
          state_d = ST_RUN;
          rem_d   = bus.num_limbs;
          sub_d   = bus.sub;
          carry_d = bus.sub;
        end
      end
      ST_RUN: begin
        if (in_acc) begin
          carry_d = add_cout;
          rem_d   = rem_q - CNT_W'(1);
          if (last_limb) begin
            state_d = ST_DRAIN;
          end
        end
      end
      ST_DRAIN: begin
        if (out_acc) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
          cout_d  = carry_q;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // A fresh limb overwrites the register in the same cycle the old one drains.
    if (in_acc) begin
      out_d.sum  = add_sum;
      out_d.last = last_limb;
      out_vld_d  = 1'b1;
    end else if (bus.out_ready) begin
      out_vld_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      rem_q     <= '0;
      sub_q     <= 1'b0;
      carry_q   <= 1'b0;
      out_q     <= '0;
      out_vld_q <= 1'b0;
      done_q    <= 1'b0;
      cout_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      rem_q     <= rem_d;
      sub_q     <= sub_d;
      carry_q   <= carry_d;
      out_q     <= out_d;
      out_vld_q <= out_vld_d;
      done_q    <= done_d;
      cout_q    <= cout_d;
    end
  end

  assign bus.in_ready  = in_rdy;
  assign bus.busy      = (state_q != ST_IDLE) || done_q;
  assign bus.out_valid = out_vld_q;
  assign bus.sum_limb  = out_q.sum;
  assign bus.out_last  = out_q.last;
  assign bus.done      = done_q;
  assign bus.carry_out = cout_q;

endmodule

// File: tb/tb_cla_mp_add_seq.sv
// Self-checking bench for cla_mp_add_seq: directed cases plus randomized operations
// compared against a wide-integer arithmetic model.
module tb_cla_mp_add_seq;

  logic clk;
  logic rst_n;

  cla_mp_add_seq_if #(.CNT_W(8)) bus ();

  cla_mp_add_seq #(.CNT_W(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests;
  int n_fail;

  logic [63:0] a_arr [256];
  logic [63:0] b_arr [256];
  logic [63:0] got_sum [$];
  logic        got_last [$];
  logic [63:0] exp_sum [8];
  logic        exp_carry;

  int   stall_from, stall_len;
  bit   rand_ready, rand_valid, mid_start;
  bit   timeout;
  int   stall_bad, stall_seen, rdy_drop, busy_low, done_delay, done_c;
  logic done_after, busy_after;

  // Operands as plain wide integers; subtraction carry means "no borrow" (A >= B).
  function automatic void model(input int n, input bit s);
    logic [512:0] wa, wb, wr;
    wa = '0;
    wb = '0;
    for (int i = 0; i < n; i++) begin
      wa[64*i +: 64] = a_arr[i];
      wb[64*i +: 64] = b_arr[i];
    end
    if (s) begin
      wr        = wa - wb;
      exp_carry = (wa >= wb);
    end else begin
      wr        = wa + wb;
      exp_carry = wr[64*n];
    end
    for (int i = 0; i < n; i++) exp_sum[i] = wr[64*i +: 64];
  endfunction

  function automatic logic [63:0] rnd_limb();
    case ($urandom_range(0, 3))
      0:       return 64'hFFFF_FFFF_FFFF_FFFF;
      1:       return 64'h0;
      default: return {$urandom, $urandom};
    endcase
  endfunction

  task automatic knobs_default();
    stall_from = 0;
    stall_len  = 0;
    rand_ready = 0;
    rand_valid = 0;
    mid_start  = 0;
  endtask

  // Runs one operation as both operand source and result sink, recording observations.
  task automatic run_op(input int n, input bit s);
    int   idx;
    bit   seen_done, holding;
    int   last_out_c;
    logic [63:0] hold_sum;
    got_sum.delete();
    got_last.delete();
    timeout = 0; stall_bad = 0; stall_seen = 0; rdy_drop = 0; busy_low = 0;
    done_delay = -1; done_c = -1;
    idx = 0; seen_done = 0; holding = 0; last_out_c = -1; hold_sum = '0;
    @(negedge clk);
    bus.start     = 1'b1;
    bus.num_limbs = n[7:0];
    bus.sub       = s;
    @(negedge clk);
    for (int c = 0; c < 400 && !seen_done; c++) begin
      bus.out_ready = rand_ready ? ($urandom_range(0, 3) != 0)
                                 : !(c >= stall_from && c < stall_from + stall_len);
      bus.in_valid  = (idx < n) && (rand_valid ? ($urandom_range(0, 3) != 0) : 1'b1);
      bus.a_limb    = a_arr[idx];
      bus.b_limb    = b_arr[idx];
      if (mid_start && c == 1) begin
        bus.start = 1'b1; bus.num_limbs = 8'd3; bus.sub = !s;
      end else begin
        bus.start = 1'b0; bus.num_limbs = '0; bus.sub = 1'b0;
      end
      #1;
      if (!bus.busy) busy_low++;
      if (bus.done) begin
        seen_done  = 1;
        done_delay = c - last_out_c;
        done_c     = c;
      end
      if (bus.out_valid && !bus.out_ready) begin
        stall_seen++;
        if (bus.in_ready) stall_bad++;
        if (holding && bus.sum_limb !== hold_sum) stall_bad++;
        hold_sum = bus.sum_limb;
        holding  = 1;
      end else begin
        holding = 0;
      end
      if (!rand_ready && !rand_valid && bus.out_ready && idx < n && !bus.in_ready) rdy_drop++;
      if (bus.in_valid && bus.in_ready) idx++;
      if (bus.out_valid && bus.out_ready) begin
        got_sum.push_back(bus.sum_limb);
        got_last.push_back(bus.out_last);
        last_out_c = c;
      end
      @(negedge clk);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    bus.start     = 1'b0;
    if (!seen_done) timeout = 1;
    #1;
    done_after = bus.done;
    busy_after = bus.busy;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.start = 0; bus.num_limbs = '0; bus.sub = 0; bus.in_valid = 0;
    bus.a_limb = '0; bus.b_limb = '0; bus.out_ready = 0;
    repeat (2) @(negedge clk);
    #1;
    n_tests++;
    if ({bus.busy, bus.in_ready, bus.out_valid, bus.out_last, bus.done, bus.carry_out} !== 6'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl: busy/in_rdy/out_vld/last/done/cout = %b, expected 000000",
               {bus.busy, bus.in_ready, bus.out_valid, bus.out_last, bus.done, bus.carry_out});
    end
    n_tests++;
    if (bus.sum_limb !== 64'h0) begin
      n_fail++;
      $display("FAIL reset_sum: got %h expected 0", bus.sum_limb);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_add_chain();
    logic [63:0] e [2];
    knobs_default();
    a_arr[0] = 64'hFFFF_FFFF_FFFF_FFFF; a_arr[1] = 64'h1;
    b_arr[0] = 64'h1;                   b_arr[1] = 64'h0;
    e[0] = 64'h0; e[1] = 64'h2;
    run_op(2, 1'b0);
    n_tests++;
    if (timeout || got_sum.size() != 2) begin
      n_fail++;
      $display("FAIL add_chain_count: got %0d limbs (timeout=%0d) expected 2", got_sum.size(), timeout);
    end
    for (int i = 0; i < got_sum.size() && i < 2; i++) begin
      n_tests++;
      if (got_sum[i] !== e[i] || got_last[i] !== (i == 1)) begin
        n_fail++;
        $display("FAIL add_chain_limb%0d: got %h last=%b expected %h last=%b",
                 i, got_sum[i], got_last[i], e[i], (i == 1));
      end
    end
    n_tests++;
    if (bus.carry_out !== 1'b0) begin
      n_fail++;
      $display("FAIL add_chain_carry: got %b expected 0", bus.carry_out);
    end
  endtask

  task automatic test_sub();
    logic [63:0] sa [2], sb [2], se [2];
    logic        sc [2];
    sa[0] = 64'd5; sb[0] = 64'd7; se[0] = 64'hFFFF_FFFF_FFFF_FFFE; sc[0] = 1'b0;
    sa[1] = 64'd7; sb[1] = 64'd5; se[1] = 64'd2;                   sc[1] = 1'b1;
    knobs_default();
    for (int k = 0; k < 2; k++) begin
      a_arr[0] = sa[k]; b_arr[0] = sb[k];
      run_op(1, 1'b1);
      n_tests++;
      if (timeout || got_sum.size() != 1 || got_sum[0] !== se[k] || got_last[0] !== 1'b1) begin
        n_fail++;
        $display("FAIL sub%0d_sum: got %h (n=%0d timeout=%0d) expected %h last=1",
                 k, (got_sum.size() > 0) ? got_sum[0] : 64'hx, got_sum.size(), timeout, se[k]);
      end
      n_tests++;
      if (bus.carry_out !== sc[k]) begin
        n_fail++;
        $display("FAIL sub%0d_carry: got %b expected %b", k, bus.carry_out, sc[k]);
      end
    end
  endtask

  task automatic test_all_ones();
    logic [63:0] e [3];
    knobs_default();
    for (int i = 0; i < 3; i++) begin
      a_arr[i] = 64'hFFFF_FFFF_FFFF_FFFF;
      b_arr[i] = 64'hFFFF_FFFF_FFFF_FFFF;
    end
    e[0] = 64'hFFFF_FFFF_FFFF_FFFE; e[1] = 64'hFFFF_FFFF_FFFF_FFFF; e[2] = 64'hFFFF_FFFF_FFFF_FFFF;
    run_op(3, 1'b0);
    n_tests++;
    if (timeout || got_sum.size() != 3) begin
      n_fail++;
      $display("FAIL ones_count: got %0d limbs (timeout=%0d) expected 3", got_sum.size(), timeout);
    end
    for (int i = 0; i < got_sum.size() && i < 3; i++) begin
      n_tests++;
      if (got_sum[i] !== e[i] || got_last[i] !== (i == 2)) begin
        n_fail++;
        $display("FAIL ones_limb%0d: got %h last=%b expected %h last=%b",
                 i, got_sum[i], got_last[i], e[i], (i == 2));
      end
    end
    n_tests++;
    if (bus.carry_out !== 1'b1) begin
      n_fail++;
      $display("FAIL ones_carry: got %b expected 1", bus.carry_out);
    end
    n_tests++;
    if (rdy_drop != 0 || done_delay != 1 || done_c != 4) begin
      n_fail++;
      $display("FAIL ones_timing: in_ready drops=%0d done_delay=%0d done_cycle=%0d expected 0/1/4",
               rdy_drop, done_delay, done_c);
    end
    n_tests++;
    if (done_after !== 1'b0 || busy_after !== 1'b0 || busy_low != 0) begin
      n_fail++;
      $display("FAIL ones_pulse: done_after=%b busy_after=%b busy_low=%0d expected 0/0/0",
               done_after, busy_after, busy_low);
    end
  endtask

  task automatic test_reset_mid_run();
    knobs_default();
    @(negedge clk);
    bus.start = 1'b1; bus.num_limbs = 8'd4; bus.sub = 1'b0;
    @(negedge clk);
    bus.start = 1'b0; bus.out_ready = 1'b1;
    bus.in_valid = 1'b1; bus.a_limb = 64'h1; bus.b_limb = 64'h1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    #1;
    n_tests++;
    if (bus.out_valid !== 1'b1 || bus.busy !== 1'b1) begin
      n_fail++;
      $display("FAIL midrst_pre: out_valid=%b busy=%b expected 1/1", bus.out_valid, bus.busy);
    end
    rst_n = 1'b0;
    #1;
    n_tests++;
    if ({bus.out_valid, bus.busy, bus.carry_out, bus.in_ready, bus.done} !== 5'b0) begin
      n_fail++;
      $display("FAIL midrst_clear: out_vld/busy/cout/in_rdy/done = %b expected 00000",
               {bus.out_valid, bus.busy, bus.carry_out, bus.in_ready, bus.done});
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 2; i++) begin
      a_arr[i] = rnd_limb();
      b_arr[i] = rnd_limb();
    end
    model(2, 1'b0);
    run_op(2, 1'b0);
    n_tests++;
    if (timeout || got_sum.size() != 2 || got_sum[0] !== exp_sum[0] || got_sum[1] !== exp_sum[1]
        || bus.carry_out !== exp_carry) begin
      n_fail++;
      $display("FAIL midrst_next: n=%0d timeout=%0d carry=%b expected 2 limbs %h %h carry=%b",
               got_sum.size(), timeout, bus.carry_out, exp_sum[0], exp_sum[1], exp_carry);
    end
  endtask

  task automatic test_backpressure();
    knobs_default();
    stall_from = 1;
    stall_len  = 5;
    for (int i = 0; i < 3; i++) begin
      a_arr[i] = {$urandom, $urandom};
      b_arr[i] = {$urandom, $urandom};
    end
    model(3, 1'b0);
    run_op(3, 1'b0);
    n_tests++;
    if (stall_seen != 5 || stall_bad != 0) begin
      n_fail++;
      $display("FAIL bp_stall: stall cycles=%0d violations=%0d expected 5/0", stall_seen, stall_bad);
    end
    n_tests++;
    if (timeout || got_sum.size() != 3) begin
      n_fail++;
      $display("FAIL bp_count: got %0d limbs (timeout=%0d) expected 3", got_sum.size(), timeout);
    end
    for (int i = 0; i < got_sum.size() && i < 3; i++) begin
      n_tests++;
      if (got_sum[i] !== exp_sum[i] || got_last[i] !== (i == 2)) begin
        n_fail++;
        $display("FAIL bp_limb%0d: got %h last=%b expected %h last=%b",
                 i, got_sum[i], got_last[i], exp_sum[i], (i == 2));
      end
    end
    n_tests++;
    if (bus.carry_out !== exp_carry) begin
      n_fail++;
      $display("FAIL bp_carry: got %b expected %b", bus.carry_out, exp_carry);
    end
  endtask

  task automatic test_ignored_start();
    int bad;
    knobs_default();
    bad = 0;
    @(negedge clk);
    bus.start = 1'b1; bus.num_limbs = 8'd0; bus.sub = 1'b0;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (4) begin
      #1;
      if (bus.busy || bus.done || bus.in_ready) bad++;
      @(negedge clk);
    end
    n_tests++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL zero_start: %0d cycles with busy/done/in_ready set, expected 0", bad);
    end
    mid_start = 1;
    for (int i = 0; i < 4; i++) begin
      a_arr[i] = rnd_limb();
      b_arr[i] = rnd_limb();
    end
    model(4, 1'b1);
    run_op(4, 1'b1);
    n_tests++;
    if (timeout || got_sum.size() != 4) begin
      n_fail++;
      $display("FAIL busy_start_count: got %0d limbs (timeout=%0d) expected 4", got_sum.size(), timeout);
    end
    for (int i = 0; i < got_sum.size() && i < 4; i++) begin
      n_tests++;
      if (got_sum[i] !== exp_sum[i]) begin
        n_fail++;
        $display("FAIL busy_start_limb%0d: got %h expected %h", i, got_sum[i], exp_sum[i]);
      end
    end
    n_tests++;
    if (bus.carry_out !== exp_carry) begin
      n_fail++;
      $display("FAIL busy_start_carry: got %b expected %b", bus.carry_out, exp_carry);
    end
    bad = 0;
    repeat (4) begin
      @(negedge clk);
      #1;
      if (bus.busy || bus.in_ready) bad++;
    end
    n_tests++;
    if (bad != 0 || busy_after !== 1'b0) begin
      n_fail++;
      $display("FAIL busy_start_after: %0d busy cycles after done (busy_after=%b), expected 0",
               bad, busy_after);
    end
  endtask

  task automatic test_max_limbs();
    int nz, nlast;
    knobs_default();
    for (int i = 0; i < 255; i++) begin
      a_arr[i] = 64'hFFFF_FFFF_FFFF_FFFF;
      b_arr[i] = (i == 0) ? 64'h1 : 64'h0;
    end
    run_op(255, 1'b0);
    n_tests++;
    if (timeout || got_sum.size() != 255 || done_c != 256) begin
      n_fail++;
      $display("FAIL max_count: got %0d limbs done_cycle=%0d (timeout=%0d) expected 255/256",
               got_sum.size(), done_c, timeout);
    end
    nz = 0; nlast = 0;
    foreach (got_sum[i]) begin
      if (got_sum[i] !== 64'h0) nz++;
      if (got_last[i] !== 1'b0) nlast++;
    end
    n_tests++;
    if (nz != 0 || nlast != 1 || got_last.size() != 255 || got_last[got_last.size()-1] !== 1'b1) begin
      n_fail++;
      $display("FAIL max_data: nonzero=%0d lasts=%0d expected 0 nonzero and single last on limb 255",
               nz, nlast);
    end
    n_tests++;
    if (bus.carry_out !== 1'b1) begin
      n_fail++;
      $display("FAIL max_carry: got %b expected 1", bus.carry_out);
    end
  endtask

  task automatic test_random();
    int n;
    bit s;
    knobs_default();
    rand_ready = 1;
    rand_valid = 1;
    for (int op = 0; op < 20; op++) begin
      n = $urandom_range(1, 6);
      s = 1'($urandom_range(0, 1));
      for (int i = 0; i < n; i++) begin
        a_arr[i] = rnd_limb();
        b_arr[i] = rnd_limb();
      end
      model(n, s);
      run_op(n, s);
      n_tests++;
      if (timeout || got_sum.size() != n || done_delay != 1 || busy_low != 0) begin
        n_fail++;
        $display("FAIL rnd%0d_ctrl: limbs=%0d timeout=%0d done_delay=%0d busy_low=%0d expected %0d/0/1/0",
                 op, got_sum.size(), timeout, done_delay, busy_low, n);
      end
      for (int i = 0; i < got_sum.size() && i < n; i++) begin
        n_tests++;
        if (got_sum[i] !== exp_sum[i] || got_last[i] !== (i == n - 1)) begin
          n_fail++;
          $display("FAIL rnd%0d_limb%0d: got %h last=%b expected %h last=%b (sub=%0d)",
                   op, i, got_sum[i], got_last[i], exp_sum[i], (i == n - 1), s);
        end
      end
      n_tests++;
      if (bus.carry_out !== exp_carry) begin
        n_fail++;
        $display("FAIL rnd%0d_carry: got %b expected %b (sub=%0d)", op, bus.carry_out, exp_carry, s);
      end
    end
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    test_reset();
    test_add_chain();
    test_sub();
    test_all_ones();
    test_reset_mid_run();
    test_backpressure();
    test_ignored_start();
    test_max_limbs();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
